// File: rtl/ta_ldd_seq.sv
// Laser-driver gate sequencer: dead-time / pulse / dead-time on a latched channel mask.
// Build option: define LDD_DEAD_TIME_EN to enable the DEAD_ON/DEAD_OFF guard states.
module ta_ldd_seq #(
  parameter int CH_N   = 3,
  parameter int CNT_W  = 32,
  parameter int DEAD_W = 8
) (
  input  logic              clk200,
  input  logic              rst,
  input  logic              cap_mode,
  input  logic [CH_N-1:0]   cap_wdis,
  input  logic [CNT_W-1:0]  cap_plus,
  input  logic              cap_trig,
  output logic              capr_rdy,
  input  logic [CH_N-1:0]   com_wdis,
  input  logic [CNT_W-1:0]  com_plus,
  input  logic              com_open,
  input  logic              com_close,
  input  logic [DEAD_W-1:0] dead_cyc,
  output logic              busy,
  output logic [CH_N-1:0]   wdis_out,
  output logic [CH_N-1:0]   LDD0_WP,
  output logic [CH_N-1:0]   LDD0_WN
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEAD_ON  = 2'd1;
  localparam logic [1:0] PULSE    = 2'd2;
  localparam logic [1:0] DEAD_OFF = 2'd3;

  logic [1:0]        state;
  logic [CH_N-1:0]   mask_r;
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  cnt;
  logic [DEAD_W-1:0] dead_r;
  logic              mode_r;

  logic              cap_start;
  logic              com_start;
  logic              abort;
  logic              dead_done;
  logic              pulse_done;
  logic [DEAD_W-1:0] dead_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef LDD_DEAD_TIME_EN
  assign dead_sel = dead_cyc;
`else
  // A zero dead length makes both guard states unreachable.
  logic unused_dead;
  assign dead_sel    = '0;
  assign unused_dead = ^dead_cyc;
`endif

  assign cap_start  = cap_mode & cap_trig & (cap_plus != '0) & (cap_wdis != '0);
  assign com_start  = ~cap_mode & com_open & ~com_close & (com_wdis != '0);
  // Close only belongs to a command-mode run; a mode flip aborts either kind.
  assign abort      = (cap_mode != mode_r) | (~mode_r & com_close);
  assign dead_done  = (cnt == CNT_W'(dead_r));
  assign pulse_done = (len_r != '0) & (cnt == len_r);

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mask_r <= '0;
      len_r  <= '0;
      cnt    <= '0;
      dead_r <= '0;
      mode_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cap_start | com_start) begin
            mask_r <= cap_mode ? cap_wdis : com_wdis;
            len_r  <= cap_mode ? cap_plus : com_plus;
            dead_r <= dead_sel;
            mode_r <= cap_mode;
            cnt    <= CNT_W'(1);
            state  <= (dead_sel != '0) ? DEAD_ON : PULSE;
          end
        end
        DEAD_ON: begin
          if (abort) begin
            cnt   <= CNT_W'(1);
            state <= DEAD_OFF;
          end else if (dead_done) begin
            cnt   <= CNT_W'(1);
            state <= PULSE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        PULSE: begin
          if (abort | pulse_done) begin
            if (dead_r != '0) begin
              cnt   <= CNT_W'(1);
              state <= DEAD_OFF;
            end else begin
              cnt    <= '0;
              mask_r <= '0;
              state  <= IDLE;
            end
          end else begin
            // Unlimited command pulses park the counter at all-ones.
            cnt <= sat_inc(cnt);
          end
        end
        DEAD_OFF: begin
          if (dead_done) begin
            cnt    <= '0;
            mask_r <= '0;
            state  <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign capr_rdy = (state == IDLE);
  assign wdis_out = mask_r;
  assign LDD0_WP  = (state == PULSE) ? mask_r : '0;
  assign LDD0_WN  = (state != IDLE) ? ~mask_r : '1;

endmodule

// File: tb/tb_ta_ldd_seq.sv
// Directed bench for ta_ldd_seq; expectations follow whether LDD_DEAD_TIME_EN is defined.
module tb_ta_ldd_seq;

  localparam int CH_N   = 3;
  localparam int CNT_W  = 32;
  localparam int DEAD_W = 8;
`ifdef LDD_DEAD_TIME_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif

  logic              clk200;
  logic              rst;
  logic              cap_mode;
  logic [CH_N-1:0]   cap_wdis;
  logic [CNT_W-1:0]  cap_plus;
  logic              cap_trig;
  logic              capr_rdy;
  logic [CH_N-1:0]   com_wdis;
  logic [CNT_W-1:0]  com_plus;
  logic              com_open;
  logic              com_close;
  logic [DEAD_W-1:0] dead_cyc;
  logic              busy;
  logic [CH_N-1:0]   wdis_out;
  logic [CH_N-1:0]   LDD0_WP;
  logic [CH_N-1:0]   LDD0_WN;

  ta_ldd_seq #(.CH_N(CH_N), .CNT_W(CNT_W), .DEAD_W(DEAD_W)) dut (
    .clk200   (clk200),
    .rst      (rst),
    .cap_mode (cap_mode),
    .cap_wdis (cap_wdis),
    .cap_plus (cap_plus),
    .cap_trig (cap_trig),
    .capr_rdy (capr_rdy),
    .com_wdis (com_wdis),
    .com_plus (com_plus),
    .com_open (com_open),
    .com_close(com_close),
    .dead_cyc (dead_cyc),
    .busy     (busy),
    .wdis_out (wdis_out),
    .LDD0_WP  (LDD0_WP),
    .LDD0_WN  (LDD0_WN)
  );

  initial clk200 = 1'b0;
  always #5 clk200 = ~clk200;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        mode;
    logic [2:0]  mask;
    logic [31:0] plus;
    logic [7:0]  dead;
    bit          ok;
    int          len;
  } vec_t;

  vec_t vt[7];

  function automatic int eff(input int d);
    return DE ? d : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk200);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [2:0] wp, input logic [2:0] wn,
                           input logic [2:0] wd, input logic b);
    chk({tag, ".wp"},      32'(LDD0_WP), 32'(wp));
    chk({tag, ".wn"},      32'(LDD0_WN), 32'(wn));
    chk({tag, ".wdis"},    32'(wdis_out), 32'(wd));
    chk({tag, ".busy"},    32'(busy), 32'(b));
    chk({tag, ".rdy"},     32'(capr_rdy), 32'(!b));
    chk({tag, ".overlap"}, 32'(LDD0_WP & LDD0_WN), 32'd0);
  endtask

  // Expected outputs k cycles after the start edge of a normal run.
  task automatic prof(input string tag, input logic [2:0] m, input int ed, input int len,
                      input int k);
    logic b;
    logic p;
    b = (k <= 2 * ed + len);
    p = (k > ed) && (k <= ed + len);
    expect_st($sformatf("%s.k%0d", tag, k), p ? m : 3'b000, b ? ~m : 3'b111,
              b ? m : 3'b000, b);
  endtask

  initial begin
    int ed;
    int len;
    logic [2:0] m;

    vt[0] = '{1'b1, 3'b101, 32'd4, 8'd2, 1'b1, 4};
    vt[1] = '{1'b1, 3'b011, 32'd3, 8'd0, 1'b1, 3};
    vt[2] = '{1'b1, 3'b111, 32'd3, 8'd3, 1'b1, 3};
    vt[3] = '{1'b1, 3'b000, 32'd4, 8'd1, 1'b0, 0};
    vt[4] = '{1'b1, 3'b101, 32'd0, 8'd1, 1'b0, 0};
    vt[5] = '{1'b0, 3'b110, 32'd5, 8'd1, 1'b1, 5};
    vt[6] = '{1'b1, 3'b001, 32'd1, 8'd1, 1'b1, 1};

    rst = 1'b1; cap_mode = 1'b1; cap_wdis = '0; cap_plus = '0; cap_trig = 1'b0;
    com_wdis = '0; com_plus = '0; com_open = 1'b0; com_close = 1'b0; dead_cyc = '0;

    step(); step();
    expect_st("reset", 3'b000, 3'b111, 3'b000, 1'b0);
    rst = 1'b0;
    step();
    expect_st("post_reset", 3'b000, 3'b111, 3'b000, 1'b0);

    for (int v = 0; v < 7; v++) begin
      ed  = vt[v].ok ? eff(int'(vt[v].dead)) : 0;
      len = vt[v].ok ? vt[v].len : 0;
      m   = vt[v].ok ? vt[v].mask : 3'b000;
      cap_mode = vt[v].mode;
      dead_cyc = vt[v].dead;
      if (vt[v].mode) begin
        cap_wdis = vt[v].mask; cap_plus = vt[v].plus; cap_trig = 1'b1;
      end else begin
        com_wdis = vt[v].mask; com_plus = vt[v].plus; com_open = 1'b1;
      end
      for (int k = 1; k <= 2 * ed + len + 2; k++) begin
        step();
        if (k == 1) begin
          cap_trig = 1'b0; com_open = 1'b0;
          cap_wdis = 3'b010; cap_plus = 32'd7; com_wdis = 3'b111; com_plus = 32'd2;
          dead_cyc = 8'd5;
        end
        prof($sformatf("vec%0d", v), m, ed, len, k);
      end
    end

    // Unlimited command pulse ended by close.
    ed = eff(1);
    cap_mode = 1'b0; com_wdis = 3'b010; com_plus = '0; dead_cyc = 8'd1; com_open = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) com_open = 1'b0;
      expect_st($sformatf("cmd.k%0d", k), (k > ed) ? 3'b010 : 3'b000, 3'b101, 3'b010, 1'b1);
    end
    com_close = 1'b1;
    for (int k = 11; k <= 12; k++) begin
      step();
      com_close = 1'b0;
      if (k <= 10 + ed) expect_st($sformatf("cmd.k%0d", k), 3'b000, 3'b101, 3'b010, 1'b1);
      else expect_st($sformatf("cmd.k%0d", k), 3'b000, 3'b111, 3'b000, 1'b0);
    end

    // Open and close together never start.
    com_open = 1'b1; com_close = 1'b1;
    step();
    com_open = 1'b0; com_close = 1'b0;
    expect_st("openclose.k1", 3'b000, 3'b111, 3'b000, 1'b0);
    step();
    expect_st("openclose.k2", 3'b000, 3'b111, 3'b000, 1'b0);

    // A trigger while busy is dropped.
    ed = eff(2);
    cap_mode = 1'b1; cap_wdis = 3'b101; cap_plus = 32'd4; dead_cyc = 8'd2; cap_trig = 1'b1;
    for (int k = 1; k <= 2 * ed + 4 + 3; k++) begin
      step();
      cap_trig = (k == 2);
      prof("retrig", 3'b101, ed, 4, k);
    end

    // Mode flip mid-pulse aborts through the trailing dead time.
    cap_wdis = 3'b111; cap_plus = 32'd10; dead_cyc = 8'd2; cap_trig = 1'b1;
    for (int k = 1; k <= ed + 2; k++) begin
      step();
      cap_trig = 1'b0;
      prof("abort", 3'b111, ed, 10, k);
    end
    cap_mode = 1'b0;
    for (int j = 1; j <= ed + 1; j++) begin
      step();
      if (j <= ed) expect_st($sformatf("abort.off%0d", j), 3'b000, 3'b000, 3'b111, 1'b1);
      else expect_st($sformatf("abort.off%0d", j), 3'b000, 3'b111, 3'b000, 1'b0);
    end
    cap_mode = 1'b1;
    step();

    // Reset mid-pulse acts without a clock edge.
    cap_trig = 1'b1;
    for (int k = 1; k <= ed + 2; k++) begin
      step();
      cap_trig = 1'b0;
      prof("rstmid", 3'b111, ed, 10, k);
    end
    #2 rst = 1'b1;
    #1;
    expect_st("rstmid.async", 3'b000, 3'b111, 3'b000, 1'b0);
    step();
    rst = 1'b0;
    step();
    expect_st("rstmid.after", 3'b000, 3'b111, 3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
